// File: rtl/fft_r2_sequencer_pkg.sv
// fft_seq_pkg
//   Shared definitions for the radix-2 FFT control sequencer.
//   - seqState_e : FSM state encoding (IDLE, LOAD, CALC, DRAIN, OUTPUT)
//   - BW_FFTP_DEFAULT / fftPoints() : point count N = 2**bw_fftp
//   - drainLen() : length D of the inter-stage hazard drain
//   - bitRev()   : bit reversal of the low 'width' bits of a value
//   No ports.
package fft_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CALC   = 3'd2,
        DRAIN  = 3'd3,
        OUTPUT = 3'd4
    } seqState_e;

    localparam int BW_FFTP_DEFAULT  = 4;
    localparam int BW_STAGE_DEFAULT = 2;

    function automatic int fftPoints(input int bwFftp);
        return 1 << bwFftp;
    endfunction

    // One cycle beyond the write-back latency, so the last write of a stage
    // is committed before the next stage issues its first read.
    function automatic int drainLen(input int latRd, input int latBf);
        return latRd + latBf + 1;
    endfunction

    function automatic logic [15:0] bitRev(input logic [15:0] value, input int width);
        logic [15:0] result;
        result = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < width) begin
                result[width-1-i] = value[i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_r2_sequencer_if.sv
// fft_r2_sequencer_if
//   Control bus between the FFT sequencer and the FFT datapath/host.
//   master modport (sequencer):
//     in : Start, InValid
//     out: LoadAddr, RdAddr, Theta, WrAddr, WrEn, WrSel, Stage,
//          StatInput, StatFFT, StatRAMReadOK, Done
//   slave modport (datapath/host): directions mirrored.
interface fft_r2_sequencer_if
    import fft_seq_pkg::*;
#(
    parameter int bw_fftp  = BW_FFTP_DEFAULT,
    parameter int bw_stage = BW_STAGE_DEFAULT
);
    logic                Start;
    logic                InValid;
    logic [bw_fftp-1:0]  LoadAddr;
    logic [bw_fftp-1:0]  RdAddr;
    logic [bw_fftp-2:0]  Theta;
    logic [bw_fftp-1:0]  WrAddr;
    logic                WrEn;
    logic                WrSel;
    logic [bw_stage-1:0] Stage;
    logic                StatInput;
    logic                StatFFT;
    logic                StatRAMReadOK;
    logic                Done;

    modport master (
        input  Start, InValid,
        output LoadAddr, RdAddr, Theta, WrAddr, WrEn, WrSel, Stage,
               StatInput, StatFFT, StatRAMReadOK, Done
    );

    modport slave (
        output Start, InValid,
        input  LoadAddr, RdAddr, Theta, WrAddr, WrEn, WrSel, Stage,
               StatInput, StatFFT, StatRAMReadOK, Done
    );
endinterface

// File: rtl/fft_r2_sequencer_addr_gen.sv
// fft_r2_addr_gen
//   Butterfly address/twiddle generator. Inputs describe the cycle about to
//   start; outputs are registered so they line up with that cycle.
//   Ports:
//     Clock, Reset     : clock, synchronous active-high reset
//     calc             : next cycle is a butterfly read cycle
//     stage, kIdx      : stage index and butterfly index for the next cycle
//     phase            : 0 = read operand A, 1 = read operand B
//     rdAddr           : RAM read address (0 outside read cycles)
//     theta            : twiddle index on phase-1 cycles, else 0
//     rdVld, rdPhase   : read qualifier and phase, feeding the write-back delay
module fft_r2_addr_gen #(
    parameter int bw_fftp  = 4,
    parameter int bw_stage = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                calc,
    input  logic [bw_stage-1:0] stage,
    input  logic [bw_fftp-2:0]  kIdx,
    input  logic                phase,
    output logic [bw_fftp-1:0]  rdAddr,
    output logic [bw_fftp-2:0]  theta,
    output logic                rdVld,
    output logic                rdPhase
);
    int                 sh;
    logic [bw_fftp-1:0] kWide;
    logic [bw_fftp-1:0] spanMask;
    logic [bw_fftp-2:0] kLow;
    logic [bw_fftp-1:0] addrA;
    logic [bw_fftp-1:0] addrB;
    logic [bw_fftp-2:0] thetaW;

    always_comb begin
        sh       = int'(stage);
        kWide    = {1'b0, kIdx};
        spanMask = (bw_fftp'(1) << sh) - 1'b1;
        kLow     = kIdx & spanMask[bw_fftp-2:0];
        // Insert a zero at bit 'stage' of k: that bit selects the A/B partner.
        addrA    = ((kWide >> sh) << (sh + 1)) | {1'b0, kLow};
        // Bit 'stage' of A is always 0, so OR-ing the span is the same as adding it.
        addrB    = addrA | (spanMask + 1'b1);
        thetaW   = kLow << (bw_fftp - 1 - sh);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rdAddr  <= '0;
            theta   <= '0;
            rdVld   <= 1'b0;
            rdPhase <= 1'b0;
        end else begin
            rdVld   <= calc;
            rdPhase <= calc & phase;
            rdAddr  <= calc ? (phase ? addrB : addrA) : '0;
            theta   <= (calc && phase) ? thetaW : '0;
        end
    end
endmodule

// File: rtl/fft_r2_sequencer.sv
// fft_r2_sequencer
//   Control sequencer for the in-place radix-2 DIT FFT core: LOAD of N
//   windowed samples, bw_fftp butterfly stages (each followed by a hazard
//   drain), then OUTPUT where the RAM may be read externally.
//   Ports:
//     Clock, Reset : clock, synchronous active-high reset
//     bus (master) : Start/InValid in; load/read/write addresses, twiddle
//                    index, write strobes, stage and status out
//   Build option FFTSEQ_BITREV_EN: when defined, LoadAddr is the
//   bit-reversed sample count (natural-order input); otherwise LoadAddr is
//   the sample count and upstream must supply bit-reversed order.
module fft_r2_sequencer
    import fft_seq_pkg::*;
#(
    parameter int bw_fftp  = BW_FFTP_DEFAULT,
    parameter int bw_stage = BW_STAGE_DEFAULT,
    parameter int lat_rd   = 2,
    parameter int lat_bf   = 2
) (
    input  logic Clock,
    input  logic Reset,
    fft_r2_sequencer_if.master bus
);
    localparam int N       = fftPoints(bw_fftp);
    localparam int LAT_WB  = lat_rd + lat_bf;
    localparam int D       = drainLen(lat_rd, lat_bf);
    localparam int DRAIN_W = ($clog2(D) > 0) ? $clog2(D) : 1;

    localparam logic [bw_fftp-1:0]  SAMPLE_LAST = bw_fftp'(N - 1);
    localparam logic [bw_fftp-2:0]  K_LAST      = '1;
    localparam logic [bw_stage-1:0] STAGE_LAST  = bw_stage'(bw_fftp - 1);
    localparam logic [DRAIN_W-1:0]  DRAIN_LAST  = DRAIN_W'(D - 1);

    seqState_e           state, stateNext;
    logic [bw_fftp-1:0]  sampleCnt, sampleNext;
    logic [bw_fftp-2:0]  kCnt, kNext;
    logic                phase, phaseNext;
    logic [bw_stage-1:0] stageCnt, stageNext;
    logic [DRAIN_W-1:0]  drainCnt, drainNext;

    logic                statInput, statFft, statReadOk, done;
    logic [bw_fftp-1:0]  loadAddr;
    logic                calcNext;
    logic [bw_fftp-1:0]  rdAddr;
    logic [bw_fftp-2:0]  theta;
    logic                rdVld, rdPhase;

    // Write-back delay line, one entry per cycle of read + butterfly latency.
    logic                vld_p  [LAT_WB];
    logic [bw_fftp-1:0]  addr_p [LAT_WB];
    logic                sel_p  [LAT_WB];

    always_comb begin
        stateNext  = state;
        sampleNext = sampleCnt;
        kNext      = kCnt;
        phaseNext  = phase;
        stageNext  = stageCnt;
        drainNext  = drainCnt;
        case (state)
            IDLE, OUTPUT: begin
                if (bus.Start) begin
                    stateNext  = LOAD;
                    sampleNext = '0;
                    stageNext  = '0;
                end
            end
            LOAD: begin
                if (bus.InValid) begin
                    sampleNext = sampleCnt + 1'b1;
                    if (sampleCnt == SAMPLE_LAST) begin
                        stateNext = CALC;
                        kNext     = '0;
                        phaseNext = 1'b0;
                        stageNext = '0;
                    end
                end
            end
            CALC: begin
                if (!phase) begin
                    phaseNext = 1'b1;
                end else begin
                    phaseNext = 1'b0;
                    if (kCnt == K_LAST) begin
                        kNext     = '0;
                        drainNext = '0;
                        stateNext = DRAIN;
                    end else begin
                        kNext = kCnt + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drainCnt == DRAIN_LAST) begin
                    drainNext = '0;
                    if (stageCnt == STAGE_LAST) begin
                        stateNext = OUTPUT;
                    end else begin
                        stageNext = stageCnt + 1'b1;
                        stateNext = CALC;
                    end
                end else begin
                    drainNext = drainCnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            sampleCnt  <= '0;
            kCnt       <= '0;
            phase      <= 1'b0;
            stageCnt   <= '0;
            drainCnt   <= '0;
            statInput  <= 1'b0;
            statFft    <= 1'b0;
            statReadOk <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= stateNext;
            sampleCnt  <= sampleNext;
            kCnt       <= kNext;
            phase      <= phaseNext;
            stageCnt   <= stageNext;
            drainCnt   <= drainNext;
            statInput  <= (stateNext == LOAD);
            statFft    <= (stateNext == CALC) || (stateNext == DRAIN);
            statReadOk <= (stateNext == OUTPUT);
            done       <= (stateNext == OUTPUT) && (state != OUTPUT);
        end
    end

    always_comb begin
        loadAddr = '0;
        if (state == LOAD) begin
`ifdef FFTSEQ_BITREV_EN
            loadAddr = bw_fftp'(bitRev(16'(sampleCnt), bw_fftp));
`else
            loadAddr = sampleCnt;
`endif
        end
    end

    // Fed with next-cycle values so its registered outputs align with the state.
    assign calcNext = (stateNext == CALC);

    fft_r2_addr_gen #(
        .bw_fftp (bw_fftp),
        .bw_stage(bw_stage)
    ) uAddrGen (
        .Clock  (Clock),
        .Reset  (Reset),
        .calc   (calcNext),
        .stage  (stageNext),
        .kIdx   (kNext),
        .phase  (phaseNext),
        .rdAddr (rdAddr),
        .theta  (theta),
        .rdVld  (rdVld),
        .rdPhase(rdPhase)
    );

    // p0 .. p(LAT_WB-1): read issue -> write-back
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < LAT_WB; i++) begin
                vld_p[i]  <= 1'b0;
                addr_p[i] <= '0;
                sel_p[i]  <= 1'b0;
            end
        end else begin
            vld_p[0]  <= rdVld;
            addr_p[0] <= rdAddr;
            sel_p[0]  <= rdPhase;
            for (int i = 1; i < LAT_WB; i++) begin
                vld_p[i]  <= vld_p[i-1];
                addr_p[i] <= addr_p[i-1];
                sel_p[i]  <= sel_p[i-1];
            end
        end
    end

    assign bus.LoadAddr      = loadAddr;
    assign bus.RdAddr        = rdAddr;
    assign bus.Theta         = theta;
    assign bus.WrEn          = vld_p[LAT_WB-1];
    assign bus.WrAddr        = addr_p[LAT_WB-1];
    assign bus.WrSel         = sel_p[LAT_WB-1];
    assign bus.Stage         = stageCnt;
    assign bus.StatInput     = statInput;
    assign bus.StatFFT       = statFft;
    assign bus.StatRAMReadOK = statReadOk;
    assign bus.Done          = done;

endmodule

// File: tb/tb_fft_r2_sequencer.sv
// tb_fft_r2_sequencer
//   Directed bench for fft_r2_sequencer at default parameters
//   (N=16, lat_rd=2, lat_bf=2, drain 5). Honours FFTSEQ_BITREV_EN for the
//   expected load addresses.
module tb_fft_r2_sequencer;
    logic Clock = 1'b0;
    logic Reset;
    int   errCnt = 0;
    int   chkCnt = 0;
    int   cnt;

    fft_r2_sequencer_if #(.bw_fftp(4), .bw_stage(2)) bus ();

    fft_r2_sequencer #(
        .bw_fftp (4),
        .bw_stage(2),
        .lat_rd  (2),
        .lat_bf  (2)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        chkCnt++;
        if (observed !== expected) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // {LoadAddr, RdAddr, Theta, WrEn, WrAddr, WrSel, Stage, StatInput, StatFFT, StatRAMReadOK, Done}
    function automatic logic [31:0] snap();
        return {9'd0, bus.LoadAddr, bus.RdAddr, bus.Theta, bus.WrEn, bus.WrAddr, bus.WrSel,
                bus.Stage, bus.StatInput, bus.StatFFT, bus.StatRAMReadOK, bus.Done};
    endfunction

    function automatic logic [31:0] packExp(input int la, input int rd, input int th, input int we,
                                            input int wa, input int ws, input int st, input int inp,
                                            input int fft, input int ok, input int dn);
        return {9'd0, 4'(la), 4'(rd), 3'(th), 1'(we), 4'(wa), 1'(ws), 2'(st),
                1'(inp), 1'(fft), 1'(ok), 1'(dn)};
    endfunction

    function automatic int addrOf(input int s, input int k, input int ph);
        int span, a;
        span = 1 << s;
        a    = ((k >> s) << (s + 1)) | (k & (span - 1));
        return ph ? a + span : a;
    endfunction

    // Expected bus state at cycle j (0 = first CALC cycle) of a frame:
    // each stage is 16 read cycles then 5 drain cycles; writes trail reads by 4.
    function automatic logic [31:0] calcExpect(input int j);
        int s, r, rd, th, we, wa, ws, jw, rw;
        s  = j / 21;
        r  = j % 21;
        rd = 0; th = 0; we = 0; wa = 0; ws = 0;
        if (r < 16) begin
            rd = addrOf(s, r / 2, r % 2);
            if (r % 2 == 1) th = ((r / 2) & ((1 << s) - 1)) << (3 - s);
        end
        if (j >= 4) begin
            jw = j - 4;
            rw = jw % 21;
            if (rw < 16) begin
                we = 1;
                wa = addrOf(jw / 21, rw / 2, rw % 2);
                ws = rw % 2;
            end
        end
        return packExp(0, rd, th, we, wa, ws, s, 0, 1, 0, 0);
    endfunction

    function automatic int expLoad(input int v);
        logic [3:0] x;
        x = 4'(v);
`ifdef FFTSEQ_BITREV_EN
        return int'({x[0], x[1], x[2], x[3]});
`else
        return int'(x);
`endif
    endfunction

    task automatic loadFrame(input bit withChecks);
        for (int i = 0; i < 16; i++) begin
            if (withChecks && i == 5) begin
                bus.InValid = 1'b0;
                tick();
                check("loadHold", snap(), packExp(expLoad(5), 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
            end
            bus.InValid = 1'b1;
            if (withChecks)
                check($sformatf("load%0d", i), snap(), packExp(expLoad(i), 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
            tick();
        end
        bus.InValid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errCnt, chkCnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.Start   = 1'b0;
        bus.InValid = 1'b0;
        Reset       = 1'b1;
        repeat (3) tick();
        check("reset", snap(), 32'd0);
        Reset = 1'b0;
        tick();
        check("idle", snap(), 32'd0);

        bus.InValid = 1'b1;
        tick();
        bus.InValid = 1'b0;
        check("idleInValid", snap(), 32'd0);

        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        loadFrame(1'b1);

        for (int j = 0; j < 84; j++) begin
            check($sformatf("calc%0d", j), snap(), calcExpect(j));
            if (j < 4)   check("s0read", bus.RdAddr, j);
            if (j == 44) check("s2k1A", bus.RdAddr, 1);
            if (j == 45) check("s2k1B", {bus.RdAddr, bus.Theta}, {4'd5, 3'd2});
            if (j == 49) check("s2k1WrB", {bus.WrEn, bus.WrAddr, bus.WrSel}, {1'b1, 4'd5, 1'b1});
            if (j == 77) check("s3k7A", bus.RdAddr, 7);
            if (j == 78) check("s3k7B", {bus.RdAddr, bus.Theta}, {4'd15, 3'd7});
            bus.Start   = (j == 10);
            bus.InValid = (j == 30);
            tick();
        end
        bus.Start   = 1'b0;
        bus.InValid = 1'b0;
        check("done", snap(), packExp(0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 1));

        for (int i = 0; i < 3; i++) begin
            bus.InValid = 1'b1;
            tick();
            check($sformatf("output%0d", i), snap(), packExp(0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0));
        end
        bus.InValid = 1'b0;

        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        check("restart", snap(), packExp(expLoad(0), 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        loadFrame(1'b0);
        repeat (40) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("abort", snap(), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("afterAbort%0d", i), snap(), 32'd0);
        end

        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        loadFrame(1'b0);
        cnt = 0;
        while (!bus.Done && cnt < 200) begin
            tick();
            cnt++;
        end
        check("doneLatency", cnt, 84);
        check("final", snap(), packExp(0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 1));

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end
endmodule
